// File: rtl/fetch_branch_gate_pkg.sv
// fetch_gate_pkg: shared definitions for the fetch-to-decode branch gate.
//   fetch_gate_state_e : gate FSM states
//   PC_W_DEF / SPEC_CNT_W_DEF : default widths for the gate and its interface
//   TRUE / FALSE : single-bit constants used in control logic
package fetch_gate_pkg;

    localparam int PC_W_DEF       = 32;
    localparam int SPEC_CNT_W_DEF = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        FG_IDLE,
        FG_SPEC,
        FG_REDIRECT
    } fetch_gate_state_e;

endpackage

// File: rtl/fetch_branch_gate_if.sv
// fetch_branch_gate_if: fetch / decode / branch-resolution signals of the gate.
//   master : the environment (fetch stage, decode, resolution unit)
//   slave  : the gate itself
//   fetch  -> gate : if_valid, if_pc, if_is_branch, if_target
//   gate   -> fetch: if_stall, redirect_valid, redirect_pc
//   gate   -> decode: id_valid, id_pc, id_spec, squash, spec_count
//   bru   <-> gate : bru_busy, bru_kill, bru_resolve, branch_detected
interface fetch_branch_gate_if
    import fetch_gate_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int SPEC_CNT_W = SPEC_CNT_W_DEF
);
    logic                  if_valid;
    logic [PC_W-1:0]       if_pc;
    logic                  if_is_branch;
    logic [PC_W-1:0]       if_target;
    logic                  if_stall;
    logic                  id_valid;
    logic [PC_W-1:0]       id_pc;
    logic                  id_spec;
    logic                  branch_detected;
    logic                  bru_busy;
    logic                  bru_kill;
    logic                  bru_resolve;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;
    logic                  squash;
    logic [SPEC_CNT_W-1:0] spec_count;

    modport master (
        output if_valid, if_pc, if_is_branch, if_target,
        output bru_busy, bru_kill, bru_resolve,
        input  if_stall, id_valid, id_pc, id_spec, branch_detected,
        input  redirect_valid, redirect_pc, squash, spec_count
    );

    modport slave (
        input  if_valid, if_pc, if_is_branch, if_target,
        input  bru_busy, bru_kill, bru_resolve,
        output if_stall, id_valid, id_pc, id_spec, branch_detected,
        output redirect_valid, redirect_pc, squash, spec_count
    );

endinterface

// File: rtl/fetch_branch_gate_spec_counter.sv
// spec_counter: saturating up-counter of speculative instructions.
//   clock, reset_n : clock, async active-low reset
//   clr            : zero the counter (wins over inc)
//   inc            : increment, ignored once saturated
//   count          : current value
//   sat            : count is at its maximum (all ones)
module spec_counter #(
    parameter int SPEC_CNT_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [SPEC_CNT_W-1:0] count,
    output logic                  sat
);

    assign sat = (count == {SPEC_CNT_W{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_branch_gate.sv
// fetch_branch_gate: forwards fetched instructions to decode, speculating
// not-taken past one conditional branch; squashes and redirects on a kill.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : fetch inputs, decode outputs, resolution-unit handshake
//
// state       | meaning
// FG_IDLE     | no branch outstanding; instructions delivered non-speculative
// FG_SPEC     | one branch outstanding; later instructions marked id_spec
// FG_REDIRECT | kill seen last cycle; fetch held while it loads redirect_pc
module fetch_branch_gate
    import fetch_gate_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int SPEC_CNT_W = SPEC_CNT_W_DEF
) (
    input logic                clock,
    input logic                reset_n,
    fetch_branch_gate_if.slave bus
);

    fetch_gate_state_e state_q, state_nxt;

    logic                  accept;
    logic                  accept_spec;
    logic                  branch_take;
    logic                  kill_take;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  cnt_sat;
    logic                  stall;
    logic [SPEC_CNT_W-1:0] cnt_q;

    spec_counter #(.SPEC_CNT_W(SPEC_CNT_W)) u_spec_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .count   (cnt_q),
        .sat     (cnt_sat)
    );

    always_comb begin
        state_nxt   = state_q;
        accept      = FALSE;
        accept_spec = FALSE;
        branch_take = FALSE;
        kill_take   = FALSE;
        cnt_clr     = FALSE;
        cnt_inc     = FALSE;
        stall       = FALSE;
        case (state_q)
            FG_IDLE: begin
                if (bus.if_valid) begin
                    if (!bus.if_is_branch) begin
                        accept = TRUE;
                    end else if (bus.bru_busy) begin
                        stall = TRUE;
                    end else begin
                        accept      = TRUE;
                        branch_take = TRUE;
                        cnt_clr     = TRUE;
                        state_nxt   = FG_SPEC;
                    end
                end
            end
            FG_SPEC: begin
                if (bus.bru_kill) begin
                    // presented instruction is dropped, not stalled
                    kill_take = TRUE;
                    cnt_clr   = TRUE;
                    state_nxt = FG_REDIRECT;
                end else if (bus.bru_resolve) begin
                    // back to IDLE rules, but a branch cannot start a new
                    // speculation in the same cycle the old one retires
                    cnt_clr   = TRUE;
                    state_nxt = FG_IDLE;
                    if (bus.if_valid) begin
                        if (bus.if_is_branch) begin
                            stall = TRUE;
                        end else begin
                            accept = TRUE;
                        end
                    end
                end else if (bus.if_valid) begin
                    if (bus.if_is_branch || cnt_sat) begin
                        stall = TRUE;
                    end else begin
                        accept      = TRUE;
                        accept_spec = TRUE;
                        cnt_inc     = TRUE;
                    end
                end
            end
            FG_REDIRECT: begin
                stall     = TRUE;
                state_nxt = FG_IDLE;
            end
            default: begin
                state_nxt = FG_IDLE;
            end
        endcase
    end

    assign bus.if_stall   = stall;
    assign bus.spec_count = cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= FG_IDLE;
            bus.id_valid        <= FALSE;
            bus.id_pc           <= '0;
            bus.id_spec         <= FALSE;
            bus.branch_detected <= FALSE;
            bus.redirect_valid  <= FALSE;
            bus.redirect_pc     <= '0;
            bus.squash          <= FALSE;
        end else begin
            state_q             <= state_nxt;
            bus.id_valid        <= accept;
            bus.id_spec         <= accept_spec;
            bus.branch_detected <= branch_take;
            bus.redirect_valid  <= kill_take;
            bus.squash          <= kill_take;
            if (accept) begin
                bus.id_pc <= bus.if_pc;
            end
            if (branch_take) begin
                bus.redirect_pc <= bus.if_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_branch_gate.sv
// tb_fetch_branch_gate: directed and random stimulus for fetch_branch_gate,
// checked against a transaction-level model of the gate's behaviour.
module tb_fetch_branch_gate;
    import fetch_gate_pkg::*;

    localparam int PW   = 32;
    localparam int SW   = 2;
    localparam int MAXS = (1 << SW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fetch_branch_gate_if #(.PC_W(PW), .SPEC_CNT_W(SW)) bus ();

    fetch_branch_gate #(.PC_W(PW), .SPEC_CNT_W(SW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model: is a branch outstanding, how many spec instrs behind it,
    // is fetch being redirected this cycle, last latched target
    bit          m_open;
    int          m_spec_n;
    bit          m_redirect;
    logic [31:0] m_target;
    bit          e_id_valid, e_id_spec, e_bd, e_squash, e_redir, e_stall;
    logic [31:0] e_id_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_open = 0; m_spec_n = 0; m_redirect = 0; m_target = '0;
        e_id_valid = 0; e_id_spec = 0; e_bd = 0; e_squash = 0; e_redir = 0;
        e_id_pc = '0;
    endtask

    task automatic chk_regs();
        chk("id_valid", 32'(bus.id_valid), 32'(e_id_valid));
        if (e_id_valid) chk("id_pc", bus.id_pc, e_id_pc);
        chk("id_spec", 32'(bus.id_spec), 32'(e_id_spec));
        chk("branch_detected", 32'(bus.branch_detected), 32'(e_bd));
        chk("squash", 32'(bus.squash), 32'(e_squash));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_redir));
        chk("redirect_pc", bus.redirect_pc, m_target);
        chk("spec_count", 32'(bus.spec_count), 32'(m_spec_n));
    endtask

    // inputs must already be driven; checks stall, clocks, checks registers
    task automatic cycle();
        bit acc, spec, kill_now, resolving, v, br;
        logic [31:0] pc, tgt;
        acc = 0; spec = 0; kill_now = 0; resolving = 0;
        #1;
        v = bus.if_valid; br = bus.if_is_branch; pc = bus.if_pc; tgt = bus.if_target;
        if (m_redirect) begin
            e_stall = 1;
        end else if (m_open && bus.bru_kill) begin
            e_stall  = 0;
            kill_now = 1;
        end else begin
            resolving = m_open && bus.bru_resolve;
            if (!v)      acc = 0;
            else if (br) acc = !m_open && !bus.bru_busy;
            else         acc = !m_open || resolving || (m_spec_n < MAXS);
            e_stall = v && !acc;
            spec    = m_open && !resolving;
        end
        chk("if_stall", 32'(bus.if_stall), 32'(e_stall));
        @(posedge clock);
        #1;
        e_squash   = kill_now;
        e_redir    = kill_now;
        e_id_valid = acc;
        e_bd       = acc && br;
        e_id_spec  = acc && spec;
        if (acc) e_id_pc = pc;
        if (m_redirect) begin
            m_redirect = 0;
        end else if (kill_now) begin
            m_open = 0; m_spec_n = 0; m_redirect = 1;
        end else begin
            if (resolving) begin
                m_open = 0; m_spec_n = 0;
            end
            if (acc && br) begin
                m_open = 1; m_spec_n = 0; m_target = tgt;
            end else if (acc && spec) begin
                m_spec_n++;
            end
        end
        chk_regs();
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit br,
                         input logic [31:0] tgt, input bit busy, input bit kill,
                         input bit res);
        bus.if_valid = v; bus.if_pc = pc; bus.if_is_branch = br; bus.if_target = tgt;
        bus.bru_busy = busy; bus.bru_kill = kill; bus.bru_resolve = res;
        cycle();
    endtask

    initial begin
        bus.if_valid = 0; bus.if_pc = '0; bus.if_is_branch = 0; bus.if_target = '0;
        bus.bru_busy = 0; bus.bru_kill = 0; bus.bru_resolve = 0;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_regs();
        #3 reset_n = 1'b1;
        @(posedge clock); #1;

        // reset mid-SPEC
        drive(1, 32'h40, 1, 32'h80, 0, 0, 0);
        drive(1, 32'h44, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        chk_regs();
        @(posedge clock); #3 reset_n = 1'b1;
        @(posedge clock); #1;
        drive(1, 32'h50, 0, 0, 0, 0, 0);
        chk("post_reset_spec", 32'(bus.id_spec), 32'd0);

        // not-taken branch
        drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
        chk("br_pc", bus.id_pc, 32'h100);
        chk("br_det", 32'(bus.branch_detected), 32'd1);
        drive(1, 32'h104, 0, 0, 0, 0, 0);
        drive(1, 32'h108, 0, 0, 0, 0, 0);
        drive(1, 32'h10c, 0, 0, 0, 0, 0);
        chk("nt_count", 32'(bus.spec_count), 32'd3);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("nt_count_clr", 32'(bus.spec_count), 32'd0);

        // taken branch
        drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
        drive(1, 32'h104, 0, 0, 0, 0, 0);
        drive(1, 32'h108, 0, 0, 0, 0, 0);
        drive(1, 32'h10c, 0, 0, 0, 0, 0);
        drive(1, 32'h110, 0, 0, 0, 1, 0);
        chk("tk_squash", 32'(bus.squash), 32'd1);
        chk("tk_redir_pc", bus.redirect_pc, 32'h200);
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        chk("tk_resume", 32'(bus.id_valid), 32'd1);

        // second branch stalls until resolved
        drive(1, 32'h300, 1, 32'h400, 0, 0, 0);
        drive(1, 32'h304, 1, 32'h500, 0, 0, 0);
        drive(1, 32'h304, 1, 32'h500, 1, 0, 0);
        drive(1, 32'h304, 1, 32'h500, 0, 0, 1);
        drive(1, 32'h304, 1, 32'h500, 0, 0, 0);
        chk("br2_det", 32'(bus.branch_detected), 32'd1);

        // saturation while still speculating behind 0x304
        for (int i = 0; i < 5; i++) drive(1, 32'h308 + 32'(4 * i), 0, 0, 0, 0, 0);
        chk("sat_count", 32'(bus.spec_count), 32'(MAXS));

        // kill and resolve together in SPEC, then together in IDLE
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("prio_squash", 32'(bus.squash), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(1, 32'h600, 0, 0, 1, 1, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 3) == 0,
                  $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
